// File: rtl/scim_bank_sequencer_pkg.sv
// Shared definitions for the bank command sequencer: states, op codes,
// default timing parameters and the compute-length helper.
package scim_bank_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_COMP    = 3'd4,
    ST_LATCH   = 3'd5,
    ST_DRAIN   = 3'd6,
    ST_DONE    = 3'd7
  } seq_state_t;

  localparam logic [1:0] SEQ_OP_WR   = 2'b00;
  localparam logic [1:0] SEQ_OP_RD   = 2'b01;
  localparam logic [1:0] SEQ_OP_COMP = 2'b10;
  localparam logic [1:0] SEQ_OP_ILL  = 2'b11;

  localparam int SEQ_CYC_W_DEF      = 5;
  localparam int SEQ_DRAIN_DEF      = 3;
  localparam int SEQ_RD_TIMEOUT_DEF = 8;

  // Total compute cycles M = N * (1 + signed), with a zero cycle count read as 1.
  function automatic int seq_comp_len(input int cycles, input logic sgn);
    int n;
    n = (cycles == 0) ? 1 : cycles;
    return sgn ? 2 * n : n;
  endfunction

endpackage

// File: rtl/scim_bank_sequencer_cycle_counter.sv
// Loadable down-counter with zero flag. One instance is time-shared by the
// compute phase, the post-latch drain and the read-completion timeout.
module scim_bank_sequencer_cycle_counter #(
  parameter int CW = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic [CW-1:0] o_count,
  output logic          o_zero
);

  logic [CW-1:0] r_count;

  // Load has priority; decrement stops at zero so the flag never wraps away.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/scim_bank_sequencer.sv
// Per-bank command sequencer. Converts one accepted command into the
// cycle-exact bank-controller strobes. COMP_EN/READ_EN/WRITE_EN are decoded
// from the state register; the remaining strobes come from one register
// stage behind that decode (M1 timing).
module scim_bank_sequencer
  import scim_bank_sequencer_pkg::*;
#(
  parameter int CYC_W      = SEQ_CYC_W_DEF,
  parameter int DRAIN      = SEQ_DRAIN_DEF,
  parameter int RD_TIMEOUT = SEQ_RD_TIMEOUT_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CYC_W-1:0] cfg_cycles,
  input  logic             cfg_signed,
  input  logic             cfg_buf_clr,
  input  logic             cmd_abort,
  input  logic             READ_DONE,
  output logic             READ_EN,
  output logic             WRITE_EN,
  output logic             COMP_EN,
  output logic             comp_positive_phase,
  output logic             SA_Latch,
  output logic             BnkCtr_En,
  output logic             BnkCtr_Clr,
  output logic             BnkCtr_Buffer_Clr,
  output logic             BnkCtr_Latch,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = CYC_W + 1;
  // Counter runs down to zero, so each phase loads its length minus one.
  // The read timeout window starts at READ_EN, one cycle before RD_WAIT.
  localparam logic [CW-1:0] L_DRAIN_LD = CW'(DRAIN - 1);
  localparam logic [CW-1:0] L_RDTO_LD  = CW'(RD_TIMEOUT - 2);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic          w_accept;
  logic          w_abort;
  logic [CW-1:0] w_cnt;
  logic          w_cnt_zero;
  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_load_val;
  logic          w_cnt_dec;
  logic          w_set_err;
  logic [CW-1:0] w_comp_ld;
  logic [CW-1:0] w_thresh;
  logic [CW-1:0] r_thresh;
  logic          r_err;
  logic          r_ctr_en;
  logic          r_pos;
  logic          r_clr;
  logic          r_bclr;
  logic          r_latch;
  logic          w_comp_en;

  assign w_accept  = (r_state == ST_IDLE) & cmd_valid & ~cmd_abort;
  assign w_abort   = (r_state != ST_IDLE) & cmd_abort;
  assign w_comp_ld = CW'(seq_comp_len(int'(cfg_cycles), cfg_signed) - 1);
  // Counter values at or above the threshold belong to the positive phase.
  assign w_thresh  = cfg_signed ? CW'(seq_comp_len(int'(cfg_cycles), 1'b0)) : '0;

  scim_bank_sequencer_cycle_counter #(
    .CW(CW)
  ) u_cnt (
    .i_clk      (CLK),
    .i_rst      (RESET),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_count    (w_cnt),
    .o_zero     (w_cnt_zero)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode plus counter load/decrement control.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    w_set_err      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            SEQ_OP_WR: w_state_nxt = ST_WR;
            SEQ_OP_RD: w_state_nxt = ST_RD;
            SEQ_OP_COMP: begin
              w_state_nxt    = ST_COMP;
              w_cnt_load     = 1'b1;
              w_cnt_load_val = w_comp_ld;
            end
            default: w_state_nxt = ST_DONE;
          endcase
        end
      end
      ST_WR: w_state_nxt = ST_DONE;
      ST_RD: begin
        w_state_nxt    = ST_RD_WAIT;
        w_cnt_load     = 1'b1;
        w_cnt_load_val = L_RDTO_LD;
      end
      ST_RD_WAIT: begin
        if (READ_DONE) begin
          w_state_nxt = ST_DONE;
        end else if (w_cnt_zero) begin
          w_state_nxt = ST_DONE;
          w_set_err   = 1'b1;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_COMP: begin
        if (w_cnt_zero) w_state_nxt = ST_LATCH;
        else            w_cnt_dec   = 1'b1;
      end
      ST_LATCH: begin
        w_state_nxt    = ST_DRAIN;
        w_cnt_load     = 1'b1;
        w_cnt_load_val = L_DRAIN_LD;
      end
      ST_DRAIN: begin
        if (w_cnt_zero) w_state_nxt = ST_DONE;
        else            w_cnt_dec   = 1'b1;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
      w_set_err   = 1'b0;
    end
  end

  // Error flag and phase threshold are captured with the command.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_err    <= 1'b0;
      r_thresh <= '0;
    end else if (w_accept) begin
      r_err    <= (cmd_op == SEQ_OP_ILL);
      r_thresh <= w_thresh;
    end else if (w_set_err) begin
      r_err    <= 1'b1;
    end
  end

  assign w_comp_en = (r_state == ST_COMP);

  // M1 strobe stage: one register behind the state decode.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ctr_en <= 1'b0;
      r_pos    <= 1'b0;
      r_clr    <= 1'b0;
      r_bclr   <= 1'b0;
      r_latch  <= 1'b0;
    end else begin
      r_ctr_en <= w_comp_en;
      r_pos    <= w_comp_en & (w_cnt >= r_thresh);
      r_clr    <= w_accept & (cmd_op == SEQ_OP_COMP);
      r_bclr   <= w_accept & (cmd_op == SEQ_OP_COMP) & cfg_buf_clr;
      r_latch  <= (r_state == ST_LATCH) & ~cmd_abort;
    end
  end

  assign COMP_EN             = w_comp_en;
  assign READ_EN             = (r_state == ST_RD);
  assign WRITE_EN            = (r_state == ST_WR);
  assign comp_positive_phase = r_pos;
  assign SA_Latch            = r_ctr_en;
  assign BnkCtr_En           = r_ctr_en;
  assign BnkCtr_Clr          = r_clr;
  assign BnkCtr_Buffer_Clr   = r_bclr;
  assign BnkCtr_Latch        = r_latch;
  assign cmd_ready           = (r_state == ST_IDLE);
  assign busy                = (r_state != ST_IDLE);
  assign done                = (r_state == ST_DONE);
  assign err                 = done & r_err;

endmodule
